// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared 32-bit ALU: round-robin grant, operand
// registers, MOD done/timeout handling and a single-cycle response pulse per op.
module alu_arbiter #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64,
  parameter int CW      = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_sel,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_sel,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_err,
  output logic             busy,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_select,
  output logic             alu_run_n,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_done
);

  typedef enum logic [1:0] {IDLE, EXEC, MOD_WAIT, RESP} state_t;

  localparam logic [2:0] SEL_MOD = 3'b111;

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]       sel_q, sel_d;
  logic             run_n_q, run_n_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_err_q, rsp_err_d;

  logic             gnt0, gnt1, accept;
  logic [WIDTH-1:0] in_a, in_b;
  logic [2:0]       in_sel;

  // On a tie the requester that did not win last time gets the grant.
  assign gnt0   = req0_valid && (!req1_valid || last_grant_q);
  assign gnt1   = req1_valid && (!req0_valid || !last_grant_q);

  assign req0_ready = reset && (state_q == IDLE) && gnt0;
  assign req1_ready = reset && (state_q == IDLE) && gnt1;
  assign accept     = req0_ready || req1_ready;

  assign in_a   = gnt1 ? req1_a   : req0_a;
  assign in_b   = gnt1 ? req1_b   : req0_b;
  assign in_sel = gnt1 ? req1_sel : req0_sel;

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latches).
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    a_d          = a_q;
    b_d          = b_q;
    sel_d        = sel_q;
    run_n_d      = run_n_q;
    cnt_d        = cnt_q;
    rsp_result_d = rsp_result_q;
    rsp_err_d    = rsp_err_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          last_grant_d = gnt1;
          id_d         = gnt1;
          a_d          = in_a;
          b_d          = in_b;
          sel_d        = in_sel;
          if (in_sel != SEL_MOD) begin
            state_d = EXEC;
          end else if (in_b != '0) begin
            state_d = MOD_WAIT;
            run_n_d = 1'b0;
            cnt_d   = '0;
          end else begin
            // Divide by zero is answered immediately without running the ALU.
            state_d      = RESP;
            rsp_result_d = '0;
            rsp_err_d    = 1'b1;
          end
        end
      end
      EXEC: begin
        rsp_result_d = alu_result;
        rsp_err_d    = 1'b0;
        state_d      = RESP;
      end
      MOD_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        // A done seen in the first wait cycle may be left over from a previous op.
        if (alu_done && (cnt_q != '0)) begin
          rsp_result_d = alu_result;
          rsp_err_d    = 1'b0;
          run_n_d      = 1'b1;
          state_d      = RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          rsp_result_d = '0;
          rsp_err_d    = 1'b1;
          run_n_d      = 1'b1;
          state_d      = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: registers take their next value with non-blocking assignments so all flops update together.
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      sel_q        <= '0;
      run_n_q      <= 1'b1;
      cnt_q        <= '0;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      a_q          <= a_d;
      b_q          <= b_d;
      sel_q        <= sel_d;
      run_n_q      <= run_n_d;
      cnt_q        <= cnt_d;
      rsp_result_q <= rsp_result_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign rsp0_valid = (state_q == RESP) && !id_q;
  assign rsp1_valid = (state_q == RESP) &&  id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = (state_q != IDLE);
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_select = sel_q;
  assign alu_run_n  = run_n_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU with configurable MOD done, a response
// scoreboard filled at each accept, and one task per scenario.
module tb_alu_arbiter;

  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 64;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             req0_valid = 1'b0, req1_valid = 1'b0;
  logic             req0_ready, req1_ready;
  logic [WIDTH-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [2:0]       req0_sel = '0, req1_sel = '0;
  logic             rsp0_valid, rsp1_valid, rsp_err, busy, alu_run_n, alu_done;
  logic [WIDTH-1:0] rsp_result, alu_a, alu_b, alu_result;
  logic [2:0]       alu_select;

  alu_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .CW(7)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_result(rsp_result), .rsp_err(rsp_err),
    .busy(busy), .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select), .alu_run_n(alu_run_n),
    .alu_result(alu_result), .alu_done(alu_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc++;

  // Behavioural ALU: MOD raises done 10 cycles after run_n falls when enabled.
  logic done_en = 1'b1;
  int   mod_cnt = 0;

  function automatic logic [WIDTH-1:0] alu_f(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic [2:0] sel);
    case (sel)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~(a | b);
      3'd4: return a << b[4:0];
      3'd5: return a + b;
      3'd6: return a - b;
      default: return (b != 0) ? a % b : '0;
    endcase
  endfunction

  always @(posedge clk) mod_cnt = alu_run_n ? 0 : mod_cnt + 1;
  assign alu_done   = done_en && !alu_run_n && (mod_cnt >= 10);
  assign alu_result = alu_f(alu_a, alu_b, alu_select);

  typedef struct {
    logic             id;
    logic [WIDTH-1:0] res;
    logic             err;
    int               lo;
    int               hi;
    int               acc;
  } exp_t;

  exp_t             sb[$];
  logic [WIDTH-1:0] last_result;
  logic             last_err, last_id;

  function automatic exp_t make_exp(input logic id, input logic [WIDTH-1:0] a,
                                    input logic [WIDTH-1:0] b, input logic [2:0] sel);
    exp_t e;
    e.id = id; e.acc = cyc + 1; e.err = 1'b0; e.lo = 2; e.hi = 2;
    if (sel != 3'd7) begin
      e.res = alu_f(a, b, sel);
    end else if (b == 0) begin
      e.res = '0; e.err = 1'b1; e.lo = 1; e.hi = 2;
    end else if (!done_en) begin
      e.res = '0; e.err = 1'b1; e.lo = TIMEOUT; e.hi = TIMEOUT + 2;
    end else begin
      e.res = a % b; e.lo = 2; e.hi = TIMEOUT + 2;
    end
    return e;
  endfunction

  // Accepts are recorded at the falling edge before the accepting rising edge.
  always @(negedge clk) begin
    if (reset) begin
      if (req0_valid && req0_ready) sb.push_back(make_exp(1'b0, req0_a, req0_b, req0_sel));
      if (req1_valid && req1_ready) sb.push_back(make_exp(1'b1, req1_a, req1_b, req1_sel));
      if (rsp0_valid || rsp1_valid) begin
        last_result = rsp_result; last_err = rsp_err; last_id = rsp1_valid;
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_rsp: got rsp0=%0b rsp1=%0b result=%h, expected no response",
                   rsp0_valid, rsp1_valid, rsp_result);
        end else begin
          exp_t e;
          int   lat;
          e   = sb.pop_front();
          lat = cyc - e.acc + 1;
          if ({rsp1_valid, rsp0_valid, rsp_result, rsp_err} !== {e.id, !e.id, e.res, e.err}) begin
            n_fail++;
            $display("FAIL rsp_data: got id=%0b/%0b result=%h err=%0b, expected id=%0b result=%h err=%0b",
                     rsp1_valid, rsp0_valid, rsp_result, rsp_err, e.id, e.res, e.err);
          end
          n_tests++;
          if (lat < e.lo || lat > e.hi) begin
            n_fail++;
            $display("FAIL rsp_latency: got %0d edges, expected %0d..%0d", lat, e.lo, e.hi);
          end
        end
      end
    end
  end

  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic id, input logic v, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic [2:0] sel);
    if (!id) begin req0_valid = v; req0_a = a; req0_b = b; req0_sel = sel; end
    else     begin req1_valid = v; req1_a = a; req1_b = b; req1_sel = sel; end
  endtask

  task automatic wait_accept(input logic id);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(id ? req1_ready : req0_ready) && k < 200);
    if (!(id ? req1_ready : req0_ready)) begin
      n_tests++; n_fail++;
      $display("FAIL accept_wait: requester %0d not granted within 200 cycles", id);
    end
    sync();
    drive(id, 1'b0, '0, '0, '0);
  endtask

  task automatic issue(input logic id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [2:0] sel);
    drive(id, 1'b1, a, b, sel);
    wait_accept(id);
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL drain: %0d responses still outstanding", sb.size());
      sb.delete();
    end
    sync();
  endtask

  task automatic check_last(input string name, input logic [WIDTH-1:0] res, input logic err,
                            input logic id);
    n_tests++;
    if ({last_result, last_err, last_id} !== {res, err, id}) begin
      n_fail++;
      $display("FAIL %s: got result=%h err=%0b id=%0b, expected result=%h err=%0b id=%0b",
               name, last_result, last_err, last_id, res, err, id);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_ready_gate: got ready0/1=%b, expected 00", {req0_ready, req1_ready});
    end
    n_tests++;
    if ({busy, alu_run_n, alu_a, alu_b, alu_select, rsp_result, rsp_err, rsp0_valid, rsp1_valid}
        !== {1'b0, 1'b1, 32'h0, 32'h0, 3'b0, 32'h0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got busy=%0b run_n=%0b a=%h b=%h sel=%0d res=%h err=%0b",
               busy, alu_run_n, alu_a, alu_b, alu_select, rsp_result, rsp_err);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    sync();
    reset = 1'b1;
    sync();
  endtask

  task automatic test_and();
    issue(1'b0, 32'h00FF550F, 32'hFF00ABFC, 3'b000);
    drain();
    check_last("req0_and", 32'h0000010C, 1'b0, 1'b0);
  endtask

  task automatic test_add_sub();
    issue(1'b1, 32'd19, 32'd82, 3'b101);
    drain();
    check_last("req1_add", 32'd101, 1'b0, 1'b1);
    issue(1'b1, 32'd82, 32'hFFFFFFED, 3'b110);
    drain();
    check_last("req1_sub", 32'd101, 1'b0, 1'b1);
  endtask

  task automatic test_both_mod();
    int k = 0;
    reset = 1'b0; sync(); reset = 1'b1;
    done_en = 1'b1;
    drive(1'b0, 1'b1, 32'd113, 32'd47, 3'b111);
    drive(1'b1, 1'b1, 32'd29, 32'd8, 3'b111);
    @(negedge clk);
    n_tests++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL tie_grant: got ready0/1=%b, expected 10", {req0_ready, req1_ready});
    end
    wait_accept(1'b0);
    do begin @(negedge clk); k++; end while (!rsp0_valid && k < 200);
    n_tests++;
    if ({rsp0_valid, rsp_result, alu_run_n} !== {1'b1, 32'd19, 1'b1}) begin
      n_fail++;
      $display("FAIL mod_first: got rsp0=%0b result=%0d run_n=%0b, expected 1 19 1",
               rsp0_valid, rsp_result, alu_run_n);
    end
    @(negedge clk);
    n_tests++;
    if ({alu_run_n, req1_ready} !== 2'b11) begin
      n_fail++;
      $display("FAIL between_ops: got run_n=%0b ready1=%0b, expected 1 1", alu_run_n, req1_ready);
    end
    sync();
    wait_accept(1'b1);
    drain();
    check_last("mod_second", 32'd5, 1'b0, 1'b1);
  endtask

  task automatic test_mod_zero();
    logic ran = 1'b0;
    int   k   = 0;
    drive(1'b0, 1'b1, 32'd123, 32'd0, 3'b111);
    wait_accept(1'b0);
    while (sb.size() != 0 && k < 20) begin
      @(negedge clk);
      if (!alu_run_n) ran = 1'b1;
      k++;
    end
    n_tests++;
    if (ran !== 1'b0) begin
      n_fail++;
      $display("FAIL mod_zero_run: got run_n low during op, expected run_n held 1");
    end
    drain();
    check_last("mod_zero", 32'd0, 1'b1, 1'b0);
  endtask

  task automatic test_timeout();
    int k = 0;
    done_en = 1'b0;
    issue(1'b1, 32'd25, 32'd47, 3'b111);
    do begin @(negedge clk); k++; end while (!rsp1_valid && k < 200);
    n_tests++;
    if ({rsp1_valid, rsp_err, rsp_result, alu_run_n, busy} !== {1'b1, 1'b1, 32'd0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL timeout_rsp: got rsp1=%0b err=%0b result=%h run_n=%0b busy=%0b",
               rsp1_valid, rsp_err, rsp_result, alu_run_n, busy);
    end
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_busy: got busy=%0b after response, expected 0", busy);
    end
    sync();
    done_en = 1'b1;
  endtask

  task automatic test_reset_abort();
    done_en = 1'b0;
    issue(1'b0, 32'd25, 32'd47, 3'b111);
    repeat (5) @(negedge clk);
    n_tests++;
    if ({alu_run_n, busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL abort_inflight: got run_n=%0b busy=%0b, expected 0 1", alu_run_n, busy);
    end
    sync();
    reset = 1'b0;
    sb.delete();
    sync();
    n_tests++;
    if ({alu_run_n, busy, rsp0_valid, rsp1_valid} !== 4'b1000) begin
      n_fail++;
      $display("FAIL abort_state: got run_n=%0b busy=%0b rsp=%0b%0b, expected 1 0 00",
               alu_run_n, busy, rsp0_valid, rsp1_valid);
    end
    reset = 1'b1;
    done_en = 1'b1;
    repeat (4) sync();
    issue(1'b1, 32'd1, 32'd2, 3'b101);
    drain();
    check_last("post_abort_add", 32'd3, 1'b0, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_and();
    test_add_sub();
    test_both_mod();
    test_mod_zero();
    test_timeout();
    test_reset_abort();
    repeat (3) sync();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
